// File: rtl/cpu_pkg.sv
// cpu_pkg: memory-port FSM state type and default widths/timeout for the single-bus CPU.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} mem_state_t;
  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 9;
  localparam int CPU_TIMEOUT_CYC = 15;
endpackage

// File: rtl/reg_n_bits.sv
// reg_n_bits: W-bit register with load enable and asynchronous active-high clear.
//   clk, clr : clock / async clear
//   ld_i     : load d_i on the rising edge
//   d_i, q_o : data in / register contents
module reg_n_bits #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or posedge clr)
    if (clr) q_o <= '0;
    else if (ld_i) q_o <= d_i;
endmodule

// File: rtl/bus_mem_interface.sv
// bus_mem_interface: MAR/MDR memory port with req/ack handshake to a variable-latency memory.
//   bus_in, MARin, MDRin : load MAR/MDR from the internal bus (IDLE only)
//   Read, Write          : start an access at MAR (Read wins if both)
//   mdr_out, mar_out     : register contents
//   busy, done, err      : status (done is a 1-cycle pulse, err is the timeout flag)
//   mem_*                : memory side; mem_ack only sampled in ACCESS
// Optional timeout: define MEM_TIMEOUT_EN to abort an access after TIMEOUT_CYC cycles without ack.
module bus_mem_interface
  import cpu_pkg::*;
#(
  parameter int DATA_W      = CPU_DATA_W,
  parameter int ADDR_W      = CPU_ADDR_W,
  parameter int TIMEOUT_CYC = CPU_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mar_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  mem_state_t state_q, state_d;
  logic we_q, we_d;
  logic idle, acc, cmd, tmo;
  assign idle = state_q == IDLE;
  assign acc  = state_q == ACCESS;
  assign cmd  = idle & (Read | Write);
  // MAR/MDR are frozen outside IDLE; MDR's only other writer is a read ack.
  reg_n_bits #(.W(ADDR_W)) u_mar (
    .clk(clk), .clr(clr), .ld_i(idle & MARin), .d_i(bus_in[ADDR_W-1:0]), .q_o(mar_out)
  );
  reg_n_bits #(.W(DATA_W)) u_mdr (
    .clk(clk), .clr(clr), .ld_i((idle & MDRin) | (acc & mem_ack & ~we_q)),
    .d_i(acc ? mem_rdata : bus_in), .q_o(mdr_out)
  );
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  // cnt_q counts elapsed ACCESS cycles; ack on the last one still wins.
  assign tmo   = acc & ~mem_ack & (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign cnt_d = cmd ? '0 : acc ? cnt_q + CW'(1) : cnt_q;
  assign err_d = cmd ? 1'b0 : tmo ? 1'b1 : err_q;
  assign err   = err_q;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    if (cmd) state_d = ACCESS;
    else if (acc & (mem_ack | tmo)) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
  end
  assign we_d = cmd ? ~Read : we_q;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
    end
  assign busy      = ~idle;
  assign done      = state_q == DONE;
  assign mem_req   = acc;
  assign mem_we    = we_q;
  assign mem_addr  = mar_out;
  assign mem_wdata = mdr_out;
endmodule

// File: tb/tb_bus_mem_interface.sv
// tb_bus_mem_interface: directed self-checking bench for bus_mem_interface.
module tb_bus_mem_interface;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] bus_in = '0;
  logic        MARin = 1'b0, MDRin = 1'b0, Read = 1'b0, Write = 1'b0;
  logic [31:0] mdr_out, mem_wdata;
  logic [8:0]  mar_out, mem_addr;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  int checks = 0;
  int errors = 0;

  bus_mem_interface dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .Write(Write), .mdr_out(mdr_out), .mar_out(mar_out),
    .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mar", mar_out, 0);
    check("rst_mdr", mdr_out, 0);
    tick();
    clr = 1'b0;
    // 1: read with zero wait states
    bus_in = 32'h0000_0012; MARin = 1'b1;
    tick();
    MARin = 1'b0;
    check("t1_mar", mar_out, 9'h012);
    Read = 1'b1;
    tick();
    Read = 1'b0;
    check("t1_req", mem_req, 1);
    check("t1_busy", busy, 1);
    check("t1_we", mem_we, 0);
    check("t1_addr", mem_addr, 9'h012);
    check("t1_done_early", done, 0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    check("t1_done", done, 1);
    check("t1_req_off", mem_req, 0);
    check("t1_mdr", mdr_out, 32'hDEAD_BEEF);
    tick();
    check("t1_done_off", done, 0);
    check("t1_idle", busy, 0);
    // 2: write with three wait states
    bus_in = 32'h1234_5678; MDRin = 1'b1;
    tick();
    MDRin = 1'b0; bus_in = 32'h0000_01FF; MARin = 1'b1;
    tick();
    MARin = 1'b0; Write = 1'b1;
    tick();
    Write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_req_wait", mem_req, 1);
      tick();
    end
    check("t2_req4", mem_req, 1);
    check("t2_we", mem_we, 1);
    check("t2_wdata", mem_wdata, 32'h1234_5678);
    check("t2_addr", mem_addr, 9'h1FF);
    check("t2_no_done", done, 0);
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
    tick();
    mem_ack = 1'b0;
    check("t2_done", done, 1);
    check("t2_mdr_kept", mdr_out, 32'h1234_5678);
    tick();
    check("t2_done_once", done, 0);
    // 3: Read+Write collision, MDRin while busy, Read during DONE
    Read = 1'b1; Write = 1'b1;
    tick();
    Read = 1'b0; Write = 1'b0;
    check("t3_we_read_wins", mem_we, 0);
    check("t3_req", mem_req, 1);
    MDRin = 1'b1; MARin = 1'b1; bus_in = 32'hFFFF_FFFF;
    tick();
    MDRin = 1'b0; MARin = 1'b0;
    check("t3_mdr_protected", mdr_out, 32'h1234_5678);
    check("t3_mar_protected", mar_out, 9'h1FF);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0;
    check("t3_done", done, 1);
    check("t3_mdr", mdr_out, 32'h0BAD_F00D);
    Read = 1'b1;
    tick();
    Read = 1'b0;
    check("t3_read_in_done_ignored", busy, 0);
    tick();
    check("t3_still_idle", mem_req, 0);
    // 4: clr mid-access
    Read = 1'b1;
    tick();
    Read = 1'b0;
    tick();
    check("t4_req_cycle2", mem_req, 1);
    clr = 1'b1;
    #1;
    check("t4_req_drop", mem_req, 0);
    check("t4_busy_drop", busy, 0);
    check("t4_mar_clr", mar_out, 0);
    check("t4_mdr_clr", mdr_out, 0);
    tick();
    clr = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0;
    check("t4_late_ack_busy", busy, 0);
    check("t4_late_ack_mdr", mdr_out, 0);
    // 6: ack held high across DONE/IDLE
    mem_ack = 1'b1; mem_rdata = 32'h0000_0055; Read = 1'b1;
    tick();
    Read = 1'b0;
    check("t6_req", mem_req, 1);
    tick();
    check("t6_done", done, 1);
    check("t6_mdr", mdr_out, 32'h0000_0055);
    tick();
    check("t6_done_once", done, 0);
    check("t6_idle", busy, 0);
    tick();
    check("t6_no_reentry", mem_req, 0);
    mem_ack = 1'b0;
    // 5: no ack at all
    Read = 1'b1;
    tick();
    Read = 1'b0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 14; i++) tick();
    check("t5_req_cycle15", mem_req, 1);
    check("t5_err_pending", err, 0);
    tick();
    check("t5_done", done, 1);
    check("t5_err", err, 1);
    check("t5_req_off", mem_req, 0);
    check("t5_mdr_kept", mdr_out, 32'h0000_0055);
    tick();
    check("t5_err_sticky", err, 1);
    Read = 1'b1;
    tick();
    Read = 1'b0;
    check("t5_err_cleared", err, 0);
    check("t5_busy_again", busy, 1);
`else
    for (int i = 0; i < 100; i++) tick();
    check("t5_still_busy", busy, 1);
    check("t5_still_req", mem_req, 1);
    check("t5_no_err", err, 0);
    check("t5_no_done", done, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
